// File: rtl/fft_stride_detect.sv
// fft_stride_detect: finds the first FFT bin above MIN_BIN whose |re|+|im| exceeds THRESH,
// plus the peak bin in that region, and presents the result on a valid/ready port.
module fft_stride_detect #(
  parameter int FFT_LEN = 1024,
  parameter int DATA_W  = 12,
  parameter int MIN_BIN = 300,
  parameter int THRESH  = 38
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              src_valid,
  output logic              src_ready,
  input  logic              src_sop,
  input  logic              src_eop,
  input  logic [1:0]        src_error,
  input  logic [DATA_W-1:0] src_real,
  input  logic [DATA_W-1:0] src_imag,
  input  logic [5:0]        src_exp,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              res_found,
  output logic [12:0]       res_stride,
  output logic [12:0]       res_peak_bin,
  output logic [DATA_W:0]   res_peak_mag,
  output logic [5:0]        res_exp,
  output logic              res_err
);
  localparam int MW = DATA_W + 1;
  localparam logic [12:0] K_LAST = 13'(FFT_LEN - 1);
  localparam logic [12:0] K_MIN = 13'(MIN_BIN);
  localparam logic [MW-1:0] THR = MW'(THRESH);
  typedef enum logic [1:0] {IDLE, FRAME, HOLD} state_t;
  state_t state_q, state_d;
  logic [12:0] k_q, k_d, stride_q, stride_d, pbin_q, pbin_d, res_stride_q, res_stride_d, res_peak_bin_q, res_peak_bin_d;
  logic [MW-1:0] pmag_q, pmag_d, res_peak_mag_q, res_peak_mag_d;
  logic [5:0] exp_q, exp_d, res_exp_q, res_exp_d;
  logic found_q, found_d, err_q, err_d, res_found_q, res_found_d, res_err_q, res_err_d;
  logic fire, start, bin_ok, brk, close, cand, hit, pk;
  logic [12:0] kk;
  logic [MW-1:0] re_x, im_x, re_abs, im_abs, mag;
  assign src_ready    = state_q != HOLD;
  assign res_valid    = state_q == HOLD;
  assign res_found    = res_found_q;
  assign res_stride   = res_stride_q;
  assign res_peak_bin = res_peak_bin_q;
  assign res_peak_mag = res_peak_mag_q;
  assign res_exp      = res_exp_q;
  assign res_err      = res_err_q;
  // Sign-extend before negating so the most negative input maps to 2^(DATA_W-1) without wrap.
  always_comb begin
    re_x   = {src_real[DATA_W-1], src_real};
    im_x   = {src_imag[DATA_W-1], src_imag};
    re_abs = re_x[MW-1] ? -re_x : re_x;
    im_abs = im_x[MW-1] ? -im_x : im_x;
    mag    = re_abs + im_abs;
  end
  always_comb begin
    fire   = src_valid && src_ready;
    start  = state_q == IDLE && fire && src_sop;
    bin_ok = start || (state_q == FRAME && fire && !src_sop);
    brk    = state_q == FRAME && fire && src_sop;
    kk     = start ? 13'd0 : k_q;
    cand   = bin_ok && kk > K_MIN;
    found_d = start ? 1'b0 : found_q;
    stride_d = start ? 13'd0 : stride_q;
    pmag_d = start ? '0 : pmag_q;
    pbin_d = start ? 13'd0 : pbin_q;
    err_d  = start ? 1'b0 : err_q;
    hit    = cand && mag > THR && !found_d;
    pk     = cand && mag > pmag_d;
    found_d  = found_d | hit;
    stride_d = hit ? kk : stride_d;
    pmag_d   = pk ? mag : pmag_d;
    pbin_d   = pk ? kk : pbin_d;
    err_d    = err_d | brk | (bin_ok && (src_error != 2'b00 || (src_eop != (kk == K_LAST))));
    close    = brk || (bin_ok && (src_eop || kk == K_LAST));
    exp_d    = start ? src_exp : exp_q;
    k_d      = bin_ok ? kk + 13'd1 : k_q;
    state_d  = close ? HOLD : start ? FRAME : (state_q == HOLD && res_ready) ? IDLE : state_q;
    res_found_d    = close ? found_d : res_found_q;
    res_stride_d   = close ? stride_d : res_stride_q;
    res_peak_bin_d = close ? pbin_d : res_peak_bin_q;
    res_peak_mag_d = close ? pmag_d : res_peak_mag_q;
    res_exp_d      = close ? exp_d : res_exp_q;
    res_err_d      = close ? err_d : res_err_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      k_q            <= '0;
      found_q        <= 1'b0;
      stride_q       <= '0;
      pbin_q         <= '0;
      pmag_q         <= '0;
      err_q          <= 1'b0;
      exp_q          <= '0;
      res_found_q    <= 1'b0;
      res_stride_q   <= '0;
      res_peak_bin_q <= '0;
      res_peak_mag_q <= '0;
      res_exp_q      <= '0;
      res_err_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      k_q            <= k_d;
      found_q        <= found_d;
      stride_q       <= stride_d;
      pbin_q         <= pbin_d;
      pmag_q         <= pmag_d;
      err_q          <= err_d;
      exp_q          <= exp_d;
      res_found_q    <= res_found_d;
      res_stride_q   <= res_stride_d;
      res_peak_bin_q <= res_peak_bin_d;
      res_peak_mag_q <= res_peak_mag_d;
      res_exp_q      <= res_exp_d;
      res_err_q      <= res_err_d;
    end
  end
endmodule

// File: doc/fft_stride_detect.md
# fft_stride_detect

Streaming consumer on the source side of the FFT IP. It accepts one frame of `FFT_LEN` complex bins per sop/eop packet and computes |re|+|im| for each bin. It reports the first bin above `MIN_BIN` whose magnitude exceeds `THRESH`, which is the image stride/height, along with the peak bin in that region. The result goes out on a valid/ready port to the downstream image-geometry logic.

## Interface
- `FFT_LEN`, 1024: bins per frame; power of two, ≤ 8192.
- `DATA_W`, 12: width of `src_real` / `src_imag`, two's complement.
- `MIN_BIN`, 300: bins with index ≤ `MIN_BIN` are never candidates.
- `THRESH`, 38: a candidate hits when its magnitude is strictly greater than this value.
- `clk` in 1: single clock; all logic uses the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `src_valid` in 1: FFT source beat valid.
- `src_ready` out 1: beat accept. A beat transfers when `src_valid && src_ready`.
- `src_sop` in 1: first bin of a frame.
- `src_eop` in 1: last bin of a frame.
- `src_error` in 2: FFT error code; any nonzero value marks the frame bad.
- `src_real` in `DATA_W`: bin real part.
- `src_imag` in `DATA_W`: bin imaginary part.
- `src_exp` in 6: block exponent. Captured at sop, reported, not used in the comparison.
- `res_valid` out 1: result available.
- `res_ready` in 1: result consumed. The result transfers when `res_valid && res_ready`.
- `res_found` out 1: a bin hit the threshold.
- `res_stride` out 13: index of the first hit bin; 0 if none.
- `res_peak_bin` out 13: index of the maximum-magnitude bin among those with index > `MIN_BIN`.
- `res_peak_mag` out `DATA_W+1`: magnitude of that peak bin.
- `res_exp` out 6: `src_exp` captured at sop.
- `res_err` out 1: the frame was malformed or carried `src_error`.

## Operation
- Magnitude per bin:
  - `mag = abs(re) + abs(im)`, computed in `DATA_W+1` unsigned.
  - abs of the most negative value gives 2^(DATA_W-1) with no wrap; for example, -2048 gives 2048.
- Bin index `k`:
  - 13-bit counter; the sop beat is k=0 and `k` increments on each accepted beat.
- State machine, three states:
  - IDLE:
    - accepted beats without sop are dropped;
    - an accepted sop beat clears the hit, peak and error registers, captures `src_exp`, processes the beat as k=0 and moves to FRAME.
  - FRAME:
    - each accepted beat updates the running results;
    - an accepted eop beat moves to HOLD.
  - HOLD:
    - `res_*` are driven from registers;
    - `res_valid` is 1 and `src_ready` is 0;
    - on `res_ready` the state returns to IDLE.
- Running results, updated per accepted beat:
  - if `k > MIN_BIN` and `mag > THRESH` and no hit has been recorded yet, set found=1 and stride=k;
  - if `k > MIN_BIN` and `mag > peak_mag`, set peak_mag=mag and peak_bin=k. A tie keeps the lower index.
- Error cases:
  - eop with `k != FFT_LEN-1`: set err=1 and close the frame normally (move to HOLD).
  - `k` reaches `FFT_LEN-1` without eop: set err=1 and move to HOLD after that beat.
  - sop in FRAME: set err=1 and close the current frame as though this beat were eop; the beat's data is not used. The next frame starts at the next sop received in IDLE.
  - nonzero `src_error` on any beat in a frame: err=1, sticky for that frame.
- Bins are processed only while in FRAME or on the opening sop beat. `src_*` values are ignored when no beat transfers.

## Timing
- Reset values:
  - `res_valid`, `res_found`, `res_err` = 0;
  - `res_stride`, `res_peak_bin`, `res_peak_mag`, `res_exp` = 0;
  - state = IDLE;
  - `src_ready` = 1 (its value is `state != HOLD`).
- Throughput: one bin per clock in IDLE and FRAME, with no bubbles.
- Latency: `res_valid` rises on the first clock edge after the eop beat is accepted. `res_*` already include that beat.
- `res_*` stay stable while `res_valid=1 && !res_ready`.
- Return to IDLE:
  - on the edge that completes the transfer, state goes to IDLE;
  - `res_valid` falls and `src_ready` rises for the next cycle;
  - `res_*` data outputs hold their last values until the next frame completes.
- A `res_ready` held high while in IDLE or FRAME has no effect.
- Reset asserted mid-frame or in HOLD: everything returns to reset values immediately, and the partial frame is discarded.
- The FFT IP stalls while `src_ready=0`, so back-to-back frames lose one HOLD cycle at minimum.

## Test plan
- Frame of 1024 zero bins with k=500 set to (re=20, im=-19), giving mag 39:
  - expect `res_found=1`, `res_stride=500`, `res_peak_bin=500`, `res_peak_mag=39`, `res_err=0`;
  - `res_valid` high 1 cycle after eop.
- Same frame with mag=38 at k=500 and mag=200 at k=250: expect `res_found=0`, `res_stride=0`, `res_peak_bin=500`, `res_peak_mag=38`.
- Hits at k=301 (mag 40) and k=700 (mag 900), with `res_ready` held low 10 cycles:
  - expect stride=301 and peak_bin=700, both stable;
  - `src_ready=0` throughout the 10 cycles and 1 the cycle after the handshake.
- Bin re=-2048, im=-2048 at k=400: expect peak_mag=4096 with no wrap.
- Error cases:
  - eop at k=511: expect `res_err=1`;
  - `src_error=2'b01` on one beat: expect `res_err=1`;
  - sop at k=600 mid-frame: expect `res_err=1`, then a clean next frame reports `res_err=0`.
- `rst` pulsed at k=800: expect `res_valid=0` and `src_ready=1`. A following clean frame reports correct results with no residue from the aborted one.
